// File: rtl/pio_pkg.sv
// Register map and edge-select encodings shared by the extended Avalon PIO
// and its input synchroniser.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Pin input conditioning: two-flop synchroniser, history flop for edge
// detection, and an arm counter that masks edges just after reset release.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [WIDTH-1:0] s3_r;
  logic [1:0]       arm_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] sel_s;

  // Synchroniser chain, edge history and saturating arm counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r  <= '0;
      s2_r  <= '0;
      s3_r  <= '0;
      arm_r <= 2'd0;
    end else begin
      s1_r <= in_port;
      s2_r <= s1_r;
      s3_r <= s2_r;
      if (arm_r != 2'd3) begin
        arm_r <= arm_r + 2'd1;
      end else begin
        arm_r <= arm_r;
      end
    end
  end

  // Edge selection; a pin already high at reset release must not look like an edge
  always_comb begin
    rise_s = s2_r & ~s3_r;
    fall_s = ~s2_r & s3_r;
    case (EDGE_TYPE)
      EDGE_RISE: sel_s = rise_s;
      EDGE_FALL: sel_s = fall_s;
      EDGE_ANY:  sel_s = rise_s | fall_s;
      default:   sel_s = rise_s;
    endcase
    if (arm_r == 2'd3) begin
      edge_pulse = sel_s;
    end else begin
      edge_pulse = '0;
    end
  end

  assign sync_in = s2_r;

endmodule

// File: rtl/avalon_pio_ext.sv
// Avalon-MM GPIO slave: per-bit direction, atomic set/clear of outputs,
// edge capture on synchronised inputs and a masked level interrupt.
module avalon_pio_ext
  import pio_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] OUT_RESET = '0,
  parameter logic [WIDTH-1:0] DIR_RESET = '0,
  parameter int               EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  logic [WIDTH-1:0] data_out_r, data_out_s;
  logic [WIDTH-1:0] dir_r, dir_s;
  logic [WIDTH-1:0] mask_r, mask_s;
  logic [WIDTH-1:0] cap_r, cap_s;
  logic [WIDTH-1:0] sync_in_s;
  logic [WIDTH-1:0] edge_pulse_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] rd_s;
  logic             wr_s;

  pio_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .sync_in    (sync_in_s),
    .edge_pulse (edge_pulse_s)
  );

  assign wr_s = chipselect & ~write_n;

  // Register next-state; a new edge beats a same-cycle write-1-to-clear
  always_comb begin
    data_out_s = data_out_r;
    dir_s      = dir_r;
    mask_s     = mask_r;
    clr_s      = '0;
    if (wr_s) begin
      case (address)
        ADDR_DATA:    data_out_s = writedata;
        ADDR_DIR:     dir_s      = writedata;
        ADDR_IRQMASK: mask_s     = writedata;
        ADDR_EDGECAP: clr_s      = writedata;
        ADDR_OUTSET:  data_out_s = data_out_r | writedata;
        ADDR_OUTCLR:  data_out_s = data_out_r & ~writedata;
        default:      data_out_s = data_out_r;
      endcase
    end else begin
      clr_s = '0;
    end
    cap_s = (cap_r & ~clr_s) | edge_pulse_s;
  end

  // Architectural registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= OUT_RESET;
      dir_r      <= DIR_RESET;
      mask_r     <= '0;
      cap_r      <= '0;
    end else begin
      data_out_r <= data_out_s;
      dir_r      <= dir_s;
      mask_r     <= mask_s;
      cap_r      <= cap_s;
    end
  end

  // Zero-wait read mux; output pins read back the driven value
  always_comb begin
    rd_s = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:    rd_s = (dir_r & data_out_r) | (~dir_r & sync_in_s);
        ADDR_DIR:     rd_s = dir_r;
        ADDR_IRQMASK: rd_s = mask_r;
        ADDR_EDGECAP: rd_s = cap_r;
        default:      rd_s = '0;
      endcase
    end else begin
      rd_s = '0;
    end
  end

  assign readdata = rd_s;
  assign out_port = data_out_r;
  assign out_en   = dir_r;
  assign irq      = |(cap_r & mask_r);

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Directed bench for avalon_pio_ext: a pin-history model checked every cycle
// plus hand-computed expectations along the stimulus sequence.
module tb_avalon_pio_ext;

  localparam int         W    = 8;
  localparam logic [7:0] ORST = 8'hA5;
  localparam logic [7:0] DRST = 8'hF0;

  logic       clk;
  logic       reset_n;
  logic [2:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic [7:0] in_port;
  logic [7:0] out_port;
  logic [7:0] out_en;
  logic       irq;

  int total;
  int bad;

  avalon_pio_ext #(
    .WIDTH     (W),
    .OUT_RESET (ORST),
    .DIR_RESET (DRST),
    .EDGE_TYPE (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .out_en     (out_en),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: register contents plus the pin value sampled at every clock edge
  // since reset release; edges are read straight from that sample history.
  logic [7:0] m_out, m_dir, m_mask, m_cap;
  logic [7:0] hist [0:1023];
  int         n;

  function automatic logic [7:0] pv(input int i);
    if (i < 1 || i > 1023) return 8'h00;
    return hist[i];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out  <= ORST;
      m_dir  <= DRST;
      m_mask <= 8'h00;
      m_cap  <= 8'h00;
      n      <= 0;
    end else begin
      if (n < 1023) hist[n+1] <= in_port;
      n <= n + 1;
      m_cap <= (m_cap & ~((chipselect && !write_n && address == 3'd3) ? writedata : 8'h00))
               | ((n >= 3) ? (pv(n-1) & ~pv(n-2)) : 8'h00);
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_out  <= writedata;
          3'd1: m_dir  <= writedata;
          3'd2: m_mask <= writedata;
          3'd4: m_out  <= m_out | writedata;
          3'd5: m_out  <= m_out & ~writedata;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0: return (m_dir & m_out) | (~m_dir & pv(n-1));
      3'd1: return m_dir;
      3'd2: return m_mask;
      3'd3: return m_cap;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("mdl_out_port", {24'd0, out_port}, {24'd0, m_out});
        check("mdl_out_en",   {24'd0, out_en},   {24'd0, m_dir});
        check("mdl_irq",      {31'd0, irq},      {31'd0, |(m_cap & m_mask)});
        if (chipselect)
          check("mdl_readdata", {24'd0, readdata}, {24'd0, exp_rd(address)});
      end
    end
  endtask

  task automatic cyc(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    check(name, {24'd0, readdata}, {24'd0, exp});
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 8'h00; in_port = 8'h00;
    fork monitor(); join_none

    // Reset values
    cyc(3);
    check("rst_out_port", {24'd0, out_port}, 32'h0000_00A5);
    check("rst_out_en",   {24'd0, out_en},   32'h0000_00F0);
    check("rst_irq",      {31'd0, irq},      32'd0);
    reset_n = 1'b1;
    cyc(4);
    rd_chk("rst_edgecap", 3'd3, 8'h00);
    rd_chk("rst_irqmask", 3'd2, 8'h00);

    // DATA / OUTSET / OUTCLR
    wr(3'd0, 8'h3C); check("data_wr",  {24'd0, out_port}, 32'h0000_003C);
    wr(3'd4, 8'h03); check("outset",   {24'd0, out_port}, 32'h0000_003F);
    wr(3'd5, 8'h30); check("outclr",   {24'd0, out_port}, 32'h0000_000F);
    rd_chk("rd_outset_zero", 3'd4, 8'h00);
    rd_chk("rd_outclr_zero", 3'd5, 8'h00);
    rd_chk("rd_rsvd6_zero",  3'd6, 8'h00);

    // Mixed-direction DATA read
    wr(3'd1, 8'h0F);
    wr(3'd0, 8'h0A);
    in_port = 8'h50;
    cyc(3);
    rd_chk("data_mixed", 3'd0, 8'h5A);
    in_port = 8'h00;
    cyc(4);
    wr(3'd3, 8'hFF);
    rd_chk("edgecap_cleared", 3'd3, 8'h00);

    // Rising edge on bit 0 with irq, then clear, then a falling edge
    wr(3'd2, 8'h01);
    in_port = 8'h01;
    cyc(2);
    check("irq_before_k2", {31'd0, irq}, 32'd0);
    cyc();
    check("irq_at_k2", {31'd0, irq}, 32'd1);
    rd_chk("edgecap_bit0", 3'd3, 8'h01);
    wr(3'd3, 8'h01);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    in_port = 8'h00;
    cyc(4);
    rd_chk("fall_no_cap", 3'd3, 8'h00);

    // Edge on bit 2 coinciding with write-1-to-clear of bit 2
    in_port = 8'h04;
    cyc(2);
    wr(3'd3, 8'h04);
    rd_chk("set_wins", 3'd3, 8'h04);
    check("irq_unmasked_bit", {31'd0, irq}, 32'd0);

    // Asynchronous reset with all pins high through release
    in_port = 8'hFF;
    reset_n = 1'b0;
    #1;
    check("async_rst_out", {24'd0, out_port}, 32'h0000_00A5);
    check("async_rst_en",  {24'd0, out_en},   32'h0000_00F0);
    cyc(3);
    reset_n = 1'b1;
    cyc(6);
    rd_chk("no_false_edge", 3'd3, 8'h00);
    in_port = 8'h7F;
    cyc(3);
    in_port = 8'hFF;
    cyc(4);
    rd_chk("bit7_only", 3'd3, 8'h80);
    check("irq_masked_off", {31'd0, irq}, 32'd0);
    wr(3'd2, 8'h80);
    check("irq_on_unmask", {31'd0, irq}, 32'd1);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avalon_pio_ext.md
Name: avalon_pio_ext

Overview:
- Parametrised Avalon-MM slave general-purpose I/O port; successor to the team's 1-bit output-only PIO.
- Adds:
  - configurable width
  - per-bit direction
  - atomic set/clear of output bits
  - synchronised inputs with edge capture
  - masked interrupt
- Sits on the SOPC system bus; drives camera/LCD control lines and gathers button/status inputs. Zero-wait-state reads.

Parameters:
- WIDTH, 8, number of I/O bits (1..32).
- OUT_RESET, 0, reset value of data_out register.
- DIR_RESET, 0, reset value of direction register (1 = output).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  WIDTH  write data.
- readdata  out  WIDTH  combinational read data.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  data_out register.
- out_en  out  WIDTH  direction register (1 = drive pin).
- irq  out  1  level interrupt, active high.

Behaviour:
- Write = chipselect & ~write_n. Read data is valid whenever chipselect is high; reads have no side effects.
- Register map:
  - 0 DATA: write loads data_out. Read returns per bit: direction ? data_out : sync_in.
  - 1 DIR: read/write direction.
  - 2 IRQMASK: read/write irq_mask.
  - 3 EDGECAP: read capture. Writing 1 to a bit clears it; writing 0 leaves it.
  - 4 OUTSET: write does data_out |= writedata; reads 0.
  - 5 OUTCLR: write does data_out &= ~writedata; reads 0.
  - 6, 7: reserved; reads 0, writes ignored.
- Reset values:
  - data_out = OUT_RESET; direction = DIR_RESET; irq_mask = 0; capture = 0.
  - Sync flops = 0; arm counter = 0.
  - Therefore out_port = OUT_RESET, out_en = DIR_RESET, irq = 0.
- Input path: 2-flop synchroniser (s1, s2) followed by history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Edge pulse selected by EDGE_TYPE.
- Latency: a pin change sampled at edge k gives s2 at k+1, capture bit set at k+2, and irq high after k+2 if the bit is masked in.
- Arm counter: 2-bit, increments each cycle after reset release, saturates at 3. Edge pulses are ignored until the counter is 3. This suppresses the false edge when a pin is high at reset release.
- Edge capture applies to all bits regardless of direction.
- Simultaneous edge pulse and write-1-to-clear on the same bit: set wins, bit stays 1.
- irq = |(capture & irq_mask), driven from registers with no combinational path from the bus. Unmasking an already-captured bit raises irq the cycle after the write.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). The arm window restarts after release.
- writedata bits above WIDTH do not exist; WIDTH defines all buses.

Decomposition:
- Shared package pio_pkg holds:
  - register address constants (ADDR_DATA .. ADDR_OUTCLR)
  - EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY)
- One sub-module, pio_sync_edge (parameters WIDTH, EDGE_TYPE):
  - contains the synchroniser, history flops and arm counter
  - outputs sync_in[WIDTH-1:0] and edge_pulse[WIDTH-1:0]
- The top level holds the registers, read mux and irq.

Test Plan:
- Reset, WIDTH=8, OUT_RESET=8'hA5, DIR_RESET=8'hF0 -> out_port=A5, out_en=F0, irq=0, EDGECAP reads 00, IRQMASK reads 00.
- Write DATA=3C, then OUTSET=03, then OUTCLR=30 -> out_port 3C, then 3F, then 0F, each visible the cycle after its write; reads of addresses 4/5 return 00.
- DIR=0F, data_out=0A, in_port=50 held for 3 cycles -> DATA reads 5A.
- EDGE_TYPE=0, IRQMASK=01, in_port[0] rises at edge k -> EDGECAP=01 and irq=1 from k+2. Write EDGECAP=01 -> irq=0 the next cycle. A falling edge on in_port[0] captures nothing.
- Edge pulse on bit 2 coincides with write EDGECAP=04 -> bit 2 stays 1.
- in_port=FF held through reset release -> no capture bits set; a later 1->0->1 on bit 7 sets EDGECAP bit 7 only.
